// File: rtl/y86_pkg.sv
// Shared Y86 fetch definitions: icode values, fetch FSM states and instruction size limit.
package y86_pkg;

    localparam int INSTR_MAX_BYTES = 10;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DONE
    } fetch_state_t;

endpackage

// File: rtl/y86_icode_len.sv
// Instruction length decode from icode; unknown icodes report length 1 and flag invalid.
import y86_pkg::*;

module y86_icode_len (
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       invalid
);

    always_comb begin
        len     = 4'd1;
        invalid = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET:             len = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: len = 4'd2;
            I_JXX, I_CALL:                    len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     len = 4'd10;
            default:                          invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Byte-serial instruction fetch: reads exactly the decoded length, then hands the
// assembled instruction to decode over valid/ready.
import y86_pkg::*;

module imem_fetch_ctrl #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        fetch_req,
    input  logic [63:0] fetch_pc,
    output logic        fetch_ready,
    output logic        mem_rd_en,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [79:0] instr_bytes,
    output logic [3:0]  instr_len,
    output logic [63:0] instr_valp,
    output logic        imem_error,
    output logic        instr_invalid
);

    fetch_state_t state, state_nxt;

    logic [3:0]                      cnt;
    logic [63:0]                     pc;
    logic [INSTR_MAX_BYTES-1:0][7:0] byte_q;
    logic [3:0]                      len_q;
    logic [63:0]                     valp_q;
    logic                            err_q;
    logic                            inv_q;

    logic [3:0]  dec_len;
    logic        dec_inv;
    logic [3:0]  len_cur;
    logic [64:0] end_addr;
    logic        pc_ok;
    logic        range_fail;
    logic        need_more;
    logic        accept;
    logic        capture;

    y86_icode_len u_icode_len (
        .icode   (mem_rdata[7:4]),
        .len     (dec_len),
        .invalid (dec_inv)
    );

    // 65-bit end address so a PC near 2^64 cannot wrap past the range check.
    assign pc_ok      = fetch_pc <= 64'(MEM_BYTES - 1);
    assign end_addr   = {1'b0, pc} + {61'd0, dec_len} - 65'd1;
    assign range_fail = (cnt == 4'd0) && (end_addr > 65'(MEM_BYTES - 1));
    assign len_cur    = (cnt == 4'd0) ? dec_len : len_q;
    assign need_more  = ({1'b0, cnt} + 5'd1) < {1'b0, len_cur};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fetch_req && !flush) begin
                    accept = 1'b1;
                    if (pc_ok) begin
                        mem_rd_en = 1'b1;
                        mem_addr  = fetch_pc;
                        state_nxt = ST_READ;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else begin
                    capture = 1'b1;
                    if (range_fail) begin
                        state_nxt = ST_DONE;
                    end else if (need_more) begin
                        mem_rd_en = 1'b1;
                        mem_addr  = pc + 64'(cnt) + 64'd1;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (flush || instr_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            pc     <= '0;
            byte_q <= '0;
            len_q  <= '0;
            valp_q <= '0;
            err_q  <= 1'b0;
            inv_q  <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            pc     <= fetch_pc;
            byte_q <= '0;
            len_q  <= '0;
            valp_q <= fetch_pc;
            err_q  <= !pc_ok;
            inv_q  <= 1'b0;
        end else if (capture) begin
            byte_q[cnt] <= mem_rdata;
            if (cnt == 4'd0) begin
                inv_q <= dec_inv;
                len_q <= range_fail ? 4'd1 : dec_len;
            end
            if (range_fail) begin
                err_q  <= 1'b1;
                valp_q <= pc + 64'd1;
            end else if (need_more) begin
                cnt <= cnt + 4'd1;
            end else begin
                valp_q <= pc + 64'(len_cur);
            end
        end
    end

    assign fetch_ready   = (state == ST_IDLE);
    assign instr_valid   = (state == ST_DONE);
    assign instr_bytes   = byte_q;
    assign instr_len     = len_q;
    assign instr_valp    = valp_q;
    assign imem_error    = err_q;
    assign instr_invalid = inv_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a byte memory model and read-address log.
module tb_imem_fetch_ctrl;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        fetch_req = 1'b0;
    logic [63:0] fetch_pc = '0;
    logic        fetch_ready;
    logic        mem_rd_en;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [79:0] instr_bytes;
    logic [3:0]  instr_len;
    logic [63:0] instr_valp;
    logic        imem_error;
    logic        instr_invalid;

    logic [7:0]  mem [MEM_BYTES];
    logic [63:0] rd_q [$];
    int          n_chk = 0;
    int          n_fail = 0;

    imem_fetch_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .fetch_req     (fetch_req),
        .fetch_pc      (fetch_pc),
        .fetch_ready   (fetch_ready),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_bytes   (instr_bytes),
        .instr_len     (instr_len),
        .instr_valp    (instr_valp),
        .imem_error    (imem_error),
        .instr_invalid (instr_invalid)
    );

    always #5 clk = ~clk;

    // Memory answers one cycle after the strobe; every strobe is logged.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            rd_q.push_back(mem_addr);
            mem_rdata <= (mem_addr < 64'(MEM_BYTES)) ? mem[mem_addr[9:0]] : 8'h00;
        end
    end

    task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Request at cycle 0; returns the cycle in which instr_valid is first seen.
    task automatic fetch(input logic [63:0] pc, output int cyc);
        fetch_pc  = pc;
        fetch_req = 1'b1;
        rd_q.delete();
        cyc = 0;
        do begin
            @(posedge clk); #1;
            fetch_req = 1'b0;
            cyc++;
        end while (!instr_valid && cyc < 20);
        if (!instr_valid) chk("valid_timeout", instr_valid, 1);
    endtask

    task automatic release_instr(input string tag);
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        chk(tag, {instr_valid, fetch_ready}, 2'b01);
    endtask

    initial begin
        int          cyc;
        int          n;
        logic        saw_valid;
        logic [79:0] b;

        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", fetch_ready, 1);
        chk("rst_valid", instr_valid, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_outs", {instr_len, imem_error, instr_invalid, instr_valp}, 0);
        chk("rst_bytes", instr_bytes, 0);
        rst_n = 1'b1;

        // irmovq at 0
        mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h0A;
        fetch(64'd0, cyc);
        b = instr_bytes;
        chk("irmov_cyc", cyc, 11);
        chk("irmov_len", instr_len, 10);
        chk("irmov_valp", instr_valp, 10);
        chk("irmov_b01", b[15:0], 16'hF230);
        chk("irmov_b2", b[23:16], 8'h0A);
        chk("irmov_flags", {imem_error, instr_invalid}, 2'b00);
        chk("irmov_nrd", rd_q.size(), 10);
        for (int i = 0; i < 10 && i < rd_q.size(); i++) chk("irmov_addr", rd_q[i], i);
        release_instr("irmov_rel");

        // OPq at 5
        mem[5] = 8'h60; mem[6] = 8'h01;
        fetch(64'd5, cyc);
        b = instr_bytes;
        chk("opq_cyc", cyc, 3);
        chk("opq_len", instr_len, 2);
        chk("opq_valp", instr_valp, 7);
        chk("opq_hi", b[79:16], 0);
        chk("opq_lo", b[15:0], 16'h0160);
        chk("opq_nrd", rd_q.size(), 2);
        release_instr("opq_rel");

        // PC out of range
        fetch(64'd1024, cyc);
        chk("pcerr_cyc", cyc, 1);
        chk("pcerr_nrd", rd_q.size(), 0);
        chk("pcerr_err", imem_error, 1);
        chk("pcerr_len", instr_len, 0);
        chk("pcerr_valp", instr_valp, 1024);
        release_instr("pcerr_rel");

        // jXX runs off the end of memory
        mem[1020] = 8'h70;
        fetch(64'd1020, cyc);
        chk("endm_cyc", cyc, 2);
        chk("endm_err", imem_error, 1);
        chk("endm_len", instr_len, 1);
        chk("endm_nrd", rd_q.size(), 1);
        chk("endm_valp", instr_valp, 1021);
        chk("endm_bytes", instr_bytes, 80'h70);
        release_instr("endm_rel");

        // irmovq ending exactly on the last byte
        mem[1014] = 8'h30;
        fetch(64'd1014, cyc);
        chk("last_cyc", cyc, 11);
        chk("last_err", imem_error, 0);
        chk("last_len", instr_len, 10);
        chk("last_valp", instr_valp, 1024);
        chk("last_nrd", rd_q.size(), 10);
        if (rd_q.size() == 10) chk("last_addr", rd_q[9], 1023);
        release_instr("last_rel");

        // call
        mem[100] = 8'h80;
        fetch(64'd100, cyc);
        chk("call_cyc", cyc, 10);
        chk("call_len", instr_len, 9);
        chk("call_valp", instr_valp, 109);
        release_instr("call_rel");

        // invalid icode, consumer stalls for 5 cycles
        mem[0] = 8'hE0;
        fetch(64'd0, cyc);
        chk("inv_cyc", cyc, 2);
        chk("inv_flag", instr_invalid, 1);
        chk("inv_err", imem_error, 0);
        chk("inv_len", instr_len, 1);
        chk("inv_valp", instr_valp, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", instr_valid, 1);
            chk("hold_outs", {instr_invalid, instr_len, instr_valp[7:0], instr_bytes[7:0]},
                {1'b1, 4'd1, 8'd1, 8'hE0});
        end
        release_instr("inv_rel");

        // flush at cycle 4 of an irmovq fetch
        mem[0] = 8'h30;
        fetch_pc  = 64'd0;
        fetch_req = 1'b1;
        rd_q.delete();
        repeat (4) begin
            @(posedge clk); #1;
            fetch_req = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_rd_en", mem_rd_en, 0);
        chk("flush_ready", fetch_ready, 1);
        chk("flush_valid", instr_valid, 0);
        n = rd_q.size();
        chk("flush_nrd", (n >= 4 && n <= 5), 1);
        saw_valid = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            saw_valid |= instr_valid;
        end
        chk("flush_novalid", saw_valid, 0);
        chk("flush_norefetch", rd_q.size(), n);

        // flush beats a simultaneous request
        fetch_req = 1'b1;
        flush     = 1'b1;
        #1;
        chk("flush_req_rd", mem_rd_en, 0);
        @(posedge clk); #1;
        fetch_req = 1'b0;
        flush     = 1'b0;
        chk("flush_req_idle", fetch_ready, 1);

        // async reset at cycle 4 of an irmovq fetch
        fetch_pc  = 64'd0;
        fetch_req = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            fetch_req = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_ready", fetch_ready, 1);
        chk("arst_rd_en", mem_rd_en, 0);
        chk("arst_valid", instr_valid, 0);
        chk("arst_bytes", instr_bytes, 0);
        chk("arst_len", instr_len, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            saw_valid |= instr_valid;
        end
        chk("arst_novalid", saw_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
